// File: rtl/traffic_pkg.sv
// Shared lamp, direction and phase encodings for the intersection controllers.
// Both the fixed-time light controller and the actuated phase scheduler use it.
package traffic_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    localparam logic [6:0] PH_A_GREEN   = 7'b0000001;
    localparam logic [6:0] PH_A_YELLOW  = 7'b0000010;
    localparam logic [6:0] PH_ALL_RED_AB = 7'b0000100;
    localparam logic [6:0] PH_B_GREEN   = 7'b0001000;
    localparam logic [6:0] PH_B_YELLOW  = 7'b0010000;
    localparam logic [6:0] PH_ALL_RED_BA = 7'b0100000;
    localparam logic [6:0] PH_PED_WALK  = 7'b1000000;

    typedef enum logic [6:0] {
        A_GREEN    = PH_A_GREEN,
        A_YELLOW   = PH_A_YELLOW,
        ALL_RED_AB = PH_ALL_RED_AB,
        B_GREEN    = PH_B_GREEN,
        B_YELLOW   = PH_B_YELLOW,
        ALL_RED_BA = PH_ALL_RED_BA,
        PED_WALK   = PH_PED_WALK
    } phase_t;

endpackage

// File: rtl/phase_dwell_counter.sv
// Dwell-time counter for a phase: clears on phase entry, counts one per tick,
// and holds once it reaches the saturation value.
module phase_dwell_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] sat,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != sat) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-road phase scheduler with latched pedestrian walk request.
// One clock tick is one second; lamp outputs are decoded from the phase register.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 2,
    parameter int WALK      = 6,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_A,
    input  logic       sensor_B,
    input  logic       ped_req,
    output logic [2:0] light_A,
    output logic [2:0] light_B,
    output logic       walk,
    output logic       ped_pending
);

    localparam int LIM = 2 ** CNT_W;

    if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || GREEN_MAX >= LIM) begin : g_bad_green
        $error("traffic_phase_scheduler: green limits out of range");
    end
    if (YELLOW < 1 || YELLOW >= LIM || ALL_RED < 1 || ALL_RED >= LIM ||
        WALK < 1 || WALK >= LIM) begin : g_bad_fixed
        $error("traffic_phase_scheduler: fixed durations out of range");
    end

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK - 1);

    phase_t           state, next_state;
    logic             next_dir, next_dir_d;
    logic             clear;
    logic [CNT_W-1:0] sat;
    logic [CNT_W-1:0] count;

    phase_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (1'b1),
        .sat    (sat),
        .count  (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ALL_RED_BA;
            next_dir <= DIR_A;
        end else begin
            state    <= next_state;
            next_dir <= next_dir_d;
        end
    end

    // Green holds while its own road has traffic, up to GREEN_MAX, but only yields to real demand.
    always_comb begin
        next_state = state;
        next_dir_d = next_dir;
        sat        = '1;
        case (state)
            A_GREEN: begin
                sat = GMAX_LAST;
                if ((sensor_B || ped_pending) && count >= GMIN_LAST &&
                    (!sensor_A || count >= GMAX_LAST))
                    next_state = A_YELLOW;
            end
            A_YELLOW:
                if (count == YEL_LAST) next_state = ALL_RED_AB;
            ALL_RED_AB:
                if (count == AR_LAST) begin
                    next_state = ped_pending ? PED_WALK : B_GREEN;
                    next_dir_d = DIR_B;
                end
            B_GREEN: begin
                sat = GMAX_LAST;
                if ((sensor_A || ped_pending) && count >= GMIN_LAST &&
                    (!sensor_B || count >= GMAX_LAST))
                    next_state = B_YELLOW;
            end
            B_YELLOW:
                if (count == YEL_LAST) next_state = ALL_RED_BA;
            ALL_RED_BA:
                if (count == AR_LAST) begin
                    next_state = ped_pending ? PED_WALK : A_GREEN;
                    next_dir_d = DIR_A;
                end
            PED_WALK:
                if (count == WALK_LAST) next_state = (next_dir == DIR_A) ? A_GREEN : B_GREEN;
            default:
                next_state = ALL_RED_BA;
        endcase
        clear = (next_state != state);
    end

    // Entering the walk phase consumes the request, even if the button is pressed on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else if (next_state == PED_WALK && state != PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req && state != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        light_A = LAMP_RED;
        light_B = LAMP_RED;
        walk    = 1'b0;
        case (state)
            A_GREEN:  light_A = LAMP_GREEN;
            A_YELLOW: light_A = LAMP_YELLOW;
            B_GREEN:  light_B = LAMP_GREEN;
            B_YELLOW: light_B = LAMP_YELLOW;
            PED_WALK: walk    = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: timing tables, corner sequences
// and randomized sensors against a phase/elapsed-seconds reference model.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int GMIN = 5, GMAX = 15, YEL = 2, AR = 2, WLK = 6;
    localparam int P_AG = 0, P_AY = 1, P_ARAB = 2, P_BG = 3, P_BY = 4, P_ARBA = 5, P_WALK = 6;

    logic       clk = 1'b0, rst = 1'b0;
    logic       sensor_A = 1'b0, sensor_B = 1'b0, ped_req = 1'b0;
    logic [2:0] light_A, light_B;
    logic       walk, ped_pending;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b1;

    int m_ph, m_t;
    bit m_dir_b, m_pend;

    typedef struct {
        bit         do_reset;
        bit         sa, sb, pr;
        int         n;
        logic [2:0] ea, eb;
        bit         ew, ep;
        string      name;
    } vec_t;
    vec_t vecs[$];

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_A    (sensor_A),
        .sensor_B    (sensor_B),
        .ped_req     (ped_req),
        .light_A     (light_A),
        .light_B     (light_B),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running need finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_ph = P_ARBA; m_t = 0; m_dir_b = 1'b0; m_pend = 1'b0;
    endfunction

    // Phases are tracked as seconds served so far; a phase of length D ends after D seconds.
    function automatic void model_step(bit sa, bit sb, bit pr);
        int nxt;
        int served;
        nxt = m_ph;
        served = m_t + 1;
        case (m_ph)
            P_AG:   if ((sb || m_pend) && served >= GMIN && (!sa || served >= GMAX)) nxt = P_AY;
            P_AY:   if (served == YEL) nxt = P_ARAB;
            P_ARAB: if (served == AR) begin nxt = m_pend ? P_WALK : P_BG; m_dir_b = 1'b1; end
            P_BG:   if ((sa || m_pend) && served >= GMIN && (!sb || served >= GMAX)) nxt = P_BY;
            P_BY:   if (served == YEL) nxt = P_ARBA;
            P_ARBA: if (served == AR) begin nxt = m_pend ? P_WALK : P_AG; m_dir_b = 1'b0; end
            P_WALK: if (served == WLK) nxt = m_dir_b ? P_BG : P_AG;
            default: nxt = P_ARBA;
        endcase
        if (nxt == P_WALK && m_ph != P_WALK) m_pend = 1'b0;
        else if (pr && m_ph != P_WALK) m_pend = 1'b1;
        m_t  = (nxt != m_ph) ? 0 : served;
        m_ph = nxt;
    endfunction

    function automatic logic [2:0] model_lamp(bit road_b);
        if (!road_b && m_ph == P_AG) return LAMP_GREEN;
        if (!road_b && m_ph == P_AY) return LAMP_YELLOW;
        if (road_b && m_ph == P_BG)  return LAMP_GREEN;
        if (road_b && m_ph == P_BY)  return LAMP_YELLOW;
        return LAMP_RED;
    endfunction

    task automatic checkOutput(input string name, input logic [2:0] ea, input logic [2:0] eb,
                               input logic ew, input logic ep);
        total++;
        if (light_A !== ea || light_B !== eb || walk !== ew || ped_pending !== ep) begin
            bad++;
            $display("[TB] FAIL %s @%0t: got A=%b B=%b walk=%b pend=%b, need A=%b B=%b walk=%b pend=%b",
                     name, $time, light_A, light_B, walk, ped_pending, ea, eb, ew, ep);
        end
    endtask

    task automatic applyStimulus(input bit sa, input bit sb, input bit pr);
        sensor_A = sa;
        sensor_B = sb;
        ped_req  = pr;
    endtask

    // One intersection second: model advances with the DUT edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(sensor_A, sensor_B, ped_req);
        @(negedge clk);
        if (model_on) begin
            checkOutput("model", model_lamp(1'b0), model_lamp(1'b1), m_ph == P_WALK, m_pend);
            total++;
            if (light_A !== LAMP_RED && light_B !== LAMP_RED) begin
                bad++;
                $display("[TB] FAIL overlap @%0t: got A=%b B=%b, need at least one 100",
                         $time, light_A, light_B);
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        model_reset();
        #1;
        checkOutput("reset_state", LAMP_RED, LAMP_RED, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic void addVec(bit r, bit sa, bit sb, bit pr, int n,
                                   logic [2:0] ea, logic [2:0] eb, bit ew, bit ep, string name);
        vec_t v;
        v.do_reset = r; v.sa = sa; v.sb = sb; v.pr = pr; v.n = n;
        v.ea = ea; v.eb = eb; v.ew = ew; v.ep = ep; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        bit sa_r, sb_r, pr_r;

        // Idle intersection: two all-red seconds, then A rests green.
        addVec(1, 0, 0, 0, 1,  LAMP_RED,    LAMP_RED,    0, 0, "s1_allred");
        addVec(0, 0, 0, 0, 1,  LAMP_GREEN,  LAMP_RED,    0, 0, "s1_green");
        addVec(0, 0, 0, 0, 50, LAMP_GREEN,  LAMP_RED,    0, 0, "s1_hold");
        // Only B has traffic.
        addVec(1, 0, 1, 0, 2,  LAMP_GREEN,  LAMP_RED,    0, 0, "s2_a_green_start");
        addVec(0, 0, 1, 0, 4,  LAMP_GREEN,  LAMP_RED,    0, 0, "s2_a_green_last");
        addVec(0, 0, 1, 0, 1,  LAMP_YELLOW, LAMP_RED,    0, 0, "s2_a_yellow");
        addVec(0, 0, 1, 0, 1,  LAMP_YELLOW, LAMP_RED,    0, 0, "s2_a_yellow_last");
        addVec(0, 0, 1, 0, 2,  LAMP_RED,    LAMP_RED,    0, 0, "s2_allred");
        addVec(0, 0, 1, 0, 1,  LAMP_RED,    LAMP_GREEN,  0, 0, "s2_b_green");
        addVec(0, 0, 1, 0, 20, LAMP_RED,    LAMP_GREEN,  0, 0, "s2_b_rest");
        // Both roads saturated: 15 s green, 38 s period.
        addVec(1, 1, 1, 0, 2,  LAMP_GREEN,  LAMP_RED,    0, 0, "s3_a_start");
        addVec(0, 1, 1, 0, 14, LAMP_GREEN,  LAMP_RED,    0, 0, "s3_a_max");
        addVec(0, 1, 1, 0, 1,  LAMP_YELLOW, LAMP_RED,    0, 0, "s3_a_yellow");
        addVec(0, 1, 1, 0, 4,  LAMP_RED,    LAMP_GREEN,  0, 0, "s3_b_start");
        addVec(0, 1, 1, 0, 14, LAMP_RED,    LAMP_GREEN,  0, 0, "s3_b_max");
        addVec(0, 1, 1, 0, 1,  LAMP_RED,    LAMP_YELLOW, 0, 0, "s3_b_yellow");
        addVec(0, 1, 1, 0, 3,  LAMP_RED,    LAMP_RED,    0, 0, "s3_allred");
        addVec(0, 1, 1, 0, 1,  LAMP_GREEN,  LAMP_RED,    0, 0, "s3_period");
        addVec(0, 1, 1, 0, 38, LAMP_GREEN,  LAMP_RED,    0, 0, "s3_period2");
        // One-second walk press during A green, no vehicles.
        addVec(1, 0, 0, 0, 3,  LAMP_GREEN,  LAMP_RED,    0, 0, "s4_a_green2");
        addVec(0, 0, 0, 1, 1,  LAMP_GREEN,  LAMP_RED,    0, 1, "s4_latched");
        addVec(0, 0, 0, 0, 2,  LAMP_GREEN,  LAMP_RED,    0, 1, "s4_green_last");
        addVec(0, 0, 0, 0, 1,  LAMP_YELLOW, LAMP_RED,    0, 1, "s4_yellow");
        addVec(0, 0, 0, 0, 3,  LAMP_RED,    LAMP_RED,    0, 1, "s4_allred");
        addVec(0, 0, 0, 0, 1,  LAMP_RED,    LAMP_RED,    1, 0, "s4_walk_first");
        addVec(0, 0, 0, 0, 5,  LAMP_RED,    LAMP_RED,    1, 0, "s4_walk_last");
        addVec(0, 0, 0, 0, 1,  LAMP_RED,    LAMP_GREEN,  0, 0, "s4_b_green");
        addVec(0, 0, 0, 0, 10, LAMP_RED,    LAMP_GREEN,  0, 0, "s4_b_rest");
        // Button held through the walk: set/clear collision, drop during walk, served again.
        addVec(1, 0, 0, 1, 1,  LAMP_RED,    LAMP_RED,    0, 1, "s5_latched");
        addVec(0, 0, 0, 1, 1,  LAMP_RED,    LAMP_RED,    1, 0, "s5_clear_wins");
        addVec(0, 0, 0, 1, 5,  LAMP_RED,    LAMP_RED,    1, 0, "s5_walk_drop");
        addVec(0, 0, 0, 1, 1,  LAMP_GREEN,  LAMP_RED,    0, 0, "s5_post_walk");
        addVec(0, 0, 0, 1, 1,  LAMP_GREEN,  LAMP_RED,    0, 1, "s5_reset_pend");
        addVec(0, 0, 0, 1, 3,  LAMP_GREEN,  LAMP_RED,    0, 1, "s5_green_last");
        addVec(0, 0, 0, 1, 1,  LAMP_YELLOW, LAMP_RED,    0, 1, "s5_yellow");
        addVec(0, 0, 0, 1, 4,  LAMP_RED,    LAMP_RED,    1, 0, "s5_walk_again");

        model_reset();
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) doReset();
            applyStimulus(vecs[i].sa, vecs[i].sb, vecs[i].pr);
            repeat (vecs[i].n) tick();
            checkOutput(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ew, vecs[i].ep);
        end

        // Randomized traffic with occasional presses and resets.
        doReset();
        sa_r = 1'b0; sb_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 7 == 0) begin
                sa_r = ($urandom_range(0, 2) != 0);
                sb_r = ($urandom_range(0, 2) != 0);
            end
            pr_r = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            applyStimulus(sa_r, sb_r, pr_r);
            tick();
            rst = 1'b0;
        end

        // Reset lands in the middle of a walk.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("s6_walk_cycle3", LAMP_RED, LAMP_RED, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("s6_reset_immediate", LAMP_RED, LAMP_RED, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("s6_restart_red", LAMP_RED, LAMP_RED, 1'b0, 1'b0);
        tick();
        checkOutput("s6_restart_green", LAMP_GREEN, LAMP_RED, 1'b0, 1'b0);

        // Corrupted phase register must fall back to the B-to-A clearance.
        model_on = 1'b0;
        force dut.state = phase_t'(7'd0);
        #2;
        release dut.state;
        tick();
        total++;
        if (dut.state !== ALL_RED_BA || dut.count !== 5'd0) begin
            bad++;
            $display("[TB] FAIL s6_recover: got state=%b count=%0d, need state=%b count=0",
                     dut.state, dut.count, ALL_RED_BA);
        end
        tick();
        tick();
        checkOutput("s6_recover_green", LAMP_GREEN, LAMP_RED, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
